// File: rtl/vga_mode_sequencer_if.sv
// Mode-switch handshake between board switch, timing generators and sequencer.
// master is the sequencer side; slave is the board/generator side.
interface vga_mode_sequencer_if;
    logic choose_vga_mode;
    logic frame_end;
    logic mode_sel;
    logic timing_rst;
    logic blank;
    logic busy;
    logic timeout_seen;

    modport master (
        input  choose_vga_mode,
        input  frame_end,
        output mode_sel,
        output timing_rst,
        output blank,
        output busy,
        output timeout_seen
    );

    modport slave (
        output choose_vga_mode,
        output frame_end,
        input  mode_sel,
        input  timing_rst,
        input  blank,
        input  busy,
        input  timeout_seen
    );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Glitch-free VGA resolution switch sequencer: debounce, frame-align, reset, settle.
// Optional frame watchdog enabled by defining VGA_MODE_SEQ_TIMEOUT_EN.
module vga_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RST_CYCLES      = 16,
    parameter int SETTLE_FRAMES   = 2,
    parameter int FRAME_TIMEOUT   = 1000000
) (
    input logic CLOCK_25,
    input logic reset_n,
    vga_mode_sequencer_if.master bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW = $clog2(RST_CYCLES + SETTLE_FRAMES + 1);

    typedef enum logic [1:0] {
        RUN,
        WAIT_FRAME,
        HOLD,
        SETTLE
    } state_e;

    state_e        state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [DW-1:0] deb_q;
    logic [DW-1:0] deb_d;
    logic [CW-1:0] cnt_q;
    logic          mode_sel_q;
    logic          trst_q;
    logic          blank_q;
    logic          busy_q;
    logic          fe_eff;

    always_comb begin
        stable_d = stable_q;
        deb_d    = '0;
        if (sync2_q != stable_q) begin
            if (deb_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            deb_q    <= '0;
        end else begin
            sync1_q  <= bus.choose_vga_mode;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            deb_q    <= deb_d;
        end
    end

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            mode_sel_q <= 1'b0;
            trst_q     <= 1'b1;
            blank_q    <= 1'b1;
            busy_q     <= 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (stable_q != mode_sel_q) begin
                        state_q <= WAIT_FRAME;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_FRAME: begin
                    // A revert after debounce cancels before any blanking
                    if (stable_q == mode_sel_q) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (fe_eff) begin
                        state_q    <= HOLD;
                        cnt_q      <= '0;
                        mode_sel_q <= stable_q;
                        trst_q     <= 1'b1;
                        blank_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_q <= SETTLE;
                        cnt_q   <= '0;
                        trst_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (fe_eff) begin
                        if (cnt_q == CW'(SETTLE_FRAMES - 1)) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                            blank_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef VGA_MODE_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(FRAME_TIMEOUT + 1);

    logic [WW-1:0] wd_q;
    logic          to_q;
    logic          wd_on;
    logic          wd_tick;

    assign wd_on   = (state_q == WAIT_FRAME) || (state_q == SETTLE);
    assign wd_tick = wd_on && (wd_q == WW'(FRAME_TIMEOUT - 1));
    assign fe_eff  = bus.frame_end | wd_tick;

    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            if (!wd_on || bus.frame_end || wd_tick) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_tick) begin
                to_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_seen = to_q;
`else
    logic unused_timeout;

    assign unused_timeout   = ^FRAME_TIMEOUT;
    assign fe_eff           = bus.frame_end;
    assign bus.timeout_seen = 1'b0;
`endif

    assign bus.mode_sel   = mode_sel_q;
    assign bus.timing_rst = trst_q;
    assign bus.blank      = blank_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer with small debounce/reset/settle values.
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_vga_mode_sequencer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    vga_mode_sequencer_if vif ();

    vga_mode_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .RST_CYCLES     (3),
        .SETTLE_FRAMES  (2),
        .FRAME_TIMEOUT  (50)
    ) dut (
        .CLOCK_25(clk),
        .reset_n (rst_n),
        .bus     (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        vif.frame_end = 1'b1;
        @(negedge clk);
        vif.frame_end = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got stuck exp finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        vif.choose_vga_mode = 1'b0;
        vif.frame_end = 1'b0;
        tick(2);
        chk("rst_mode", vif.mode_sel, 1'b0);
        chk("rst_trst", vif.timing_rst, 1'b1);
        chk("rst_blank", vif.blank, 1'b1);
        chk("rst_busy", vif.busy, 1'b1);
        chk("rst_to", vif.timeout_seen, 1'b0);

        // 1: power-up HOLD, frame_end in HOLD ignored, then settle
        rst_n = 1'b1;
        tick(1);
        chk("s1_hold1", vif.timing_rst, 1'b1);
        pulse();
        chk("s1_hold2", vif.timing_rst, 1'b1);
        chk("s1_hmode", vif.mode_sel, 1'b0);
        tick(1);
        chk("s1_rel", vif.timing_rst, 1'b0);
        chk("s1_blk", vif.blank, 1'b1);
        pulse();
        chk("s1_f1blk", vif.blank, 1'b1);
        chk("s1_f1busy", vif.busy, 1'b1);
        pulse();
        chk("s1_runblk", vif.blank, 1'b0);
        chk("s1_runbusy", vif.busy, 1'b0);
        pulse();
        chk("s1_runfe", vif.busy, 1'b0);

        // 3: 3-cycle glitch is rejected
        vif.choose_vga_mode = 1'b1;
        tick(3);
        vif.choose_vga_mode = 1'b0;
        tick(12);
        chk("s3_busy", vif.busy, 1'b0);
        chk("s3_mode", vif.mode_sel, 1'b0);

        // 4: debounced to 1 then back to 0 before frame_end
        vif.choose_vga_mode = 1'b1;
        tick(6);
        chk("s4_pre", vif.busy, 1'b0);
        tick(1);
        chk("s4_wf", vif.busy, 1'b1);
        chk("s4_wfblk", vif.blank, 1'b0);
        vif.choose_vga_mode = 1'b0;
        tick(6);
        chk("s4_still", vif.busy, 1'b1);
        chk("s4_blk", vif.blank, 1'b0);
        tick(1);
        chk("s4_run", vif.busy, 1'b0);
        chk("s4_mode", vif.mode_sel, 1'b0);
        chk("s4_blk2", vif.blank, 1'b0);

        // 2: full switch to mode 1
        vif.choose_vga_mode = 1'b1;
        tick(7);
        chk("s2_wf", vif.busy, 1'b1);
        chk("s2_wtrst", vif.timing_rst, 1'b0);
        chk("s2_wmode", vif.mode_sel, 1'b0);
        pulse();
        chk("s2_mode", vif.mode_sel, 1'b1);
        chk("s2_trst", vif.timing_rst, 1'b1);
        chk("s2_blk", vif.blank, 1'b1);
        tick(2);
        chk("s2_trst3", vif.timing_rst, 1'b1);
        tick(1);
        chk("s2_trst4", vif.timing_rst, 1'b0);
        chk("s2_sblk", vif.blank, 1'b1);
        pulse();
        chk("s2_f1", vif.blank, 1'b1);
        pulse();
        chk("s2_run", vif.blank, 1'b0);
        chk("s2_rmode", vif.mode_sel, 1'b1);

        // 5: toggle during SETTLE, then an immediate second sequence
        vif.choose_vga_mode = 1'b0;
        tick(7);
        chk("s5_wf", vif.busy, 1'b1);
        pulse();
        chk("s5_mode0", vif.mode_sel, 1'b0);
        tick(3);
        chk("s5_settle", vif.timing_rst, 1'b0);
        vif.choose_vga_mode = 1'b1;
        tick(8);
        chk("s5_noabort", vif.blank, 1'b1);
        chk("s5_smode", vif.mode_sel, 1'b0);
        pulse();
        pulse();
        chk("s5_run", vif.busy, 1'b0);
        chk("s5_rblk", vif.blank, 1'b0);
        chk("s5_rmode", vif.mode_sel, 1'b0);
        tick(1);
        chk("s5_wf2", vif.busy, 1'b1);
        chk("s5_wblk", vif.blank, 1'b0);
        pulse();
        chk("s5_mode1", vif.mode_sel, 1'b1);
        chk("s5_trst", vif.timing_rst, 1'b1);
        tick(3);
        pulse();
        pulse();
        chk("s5_done", vif.blank, 1'b0);
        chk("s5_dmode", vif.mode_sel, 1'b1);

        // 6: no frame_end after a request
        vif.choose_vga_mode = 1'b0;
        tick(7);
        chk("s6_wf", vif.busy, 1'b1);
`ifdef VGA_MODE_SEQ_TIMEOUT_EN
        tick(49);
        chk("s6_w49", vif.timing_rst, 1'b0);
        chk("s6_to49", vif.timeout_seen, 1'b0);
        tick(1);
        chk("s6_hold", vif.timing_rst, 1'b1);
        chk("s6_hmode", vif.mode_sel, 1'b0);
        chk("s6_to", vif.timeout_seen, 1'b1);
        tick(3);
        chk("s6_settle", vif.timing_rst, 1'b0);
        tick(99);
        chk("s6_s99", vif.blank, 1'b1);
        tick(1);
        chk("s6_run", vif.blank, 1'b0);
        chk("s6_rbusy", vif.busy, 1'b0);
        chk("s6_sticky", vif.timeout_seen, 1'b1);
        vif.choose_vga_mode = 1'b1;
        tick(7);
        pulse();
        chk("s6_mode1", vif.mode_sel, 1'b1);
        tick(1);
`else
        tick(60);
        chk("s6_wait", vif.busy, 1'b1);
        chk("s6_trst", vif.timing_rst, 1'b0);
        chk("s6_blk", vif.blank, 1'b0);
        chk("s6_mode", vif.mode_sel, 1'b1);
        chk("s6_to0", vif.timeout_seen, 1'b0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_to", vif.timeout_seen, 1'b0);
        chk("ar_mode", vif.mode_sel, 1'b0);
        chk("ar_trst", vif.timing_rst, 1'b1);
        chk("ar_blk", vif.blank, 1'b1);
        chk("ar_busy", vif.busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        chk("ar_hold", vif.timing_rst, 1'b1);
        chk("ar_hmode", vif.mode_sel, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_mode_sequencer.md
Name: vga_mode_sequencer

Overview:
Sequences glitch-free switching of the VGA demonstrator between its two resolution modes (640x480 on 25 MHz timing, alternate mode on 29.5 MHz timing).
- Synchronises and debounces the raw choose_vga_mode switch.
- Waits for a frame boundary, then blanks RGB and holds the timing generators in reset while the mode mux changes.
- Releases the generators and keeps video blanked for a number of settle frames before resuming.
- Sits between the board switch input and the timing-generator/RGB output mux.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive CLOCK_25 cycles the synced switch must differ from the current stable value before the change is accepted (10 ms).
RST_CYCLES, 16, cycles timing_rst is held high during a switch (must be >= 1).
SETTLE_FRAMES, 2, frame_end pulses counted with timing released before unblanking (must be >= 1).
FRAME_TIMEOUT, 1000000, cycles without frame_end before forced progress (optional feature only).

Ports:
CLOCK_25  input  1  sole clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
choose_vga_mode  input  1  raw board switch, asynchronous; 0 = mode 0, 1 = mode 1
frame_end  input  1  one-cycle pulse from the active timing generator at vsync start, synchronous to CLOCK_25
mode_sel  output  1  registered mode select to the timing/clock mux
timing_rst  output  1  registered active-high reset to both timing generators
blank  output  1  registered; 1 forces VGA_RED/GREEN/BLUE to 0
busy  output  1  1 whenever state is not RUN
timeout_seen  output  1  sticky; set on any forced timeout progress

Behaviour:
- Reset (reset_n low, async): state HOLD, mode_sel=0, timing_rst=1, blank=1, busy=1, timeout_seen=0, all counters 0, sync flops 0, stable_mode=0.
- Sync: two-flop synchroniser on choose_vga_mode, producing sw_s.
- Debounce:
  - While sw_s != stable_mode, the debounce counter increments every cycle.
  - On reaching DEBOUNCE_CYCLES, stable_mode <= sw_s and the counter clears.
  - Any cycle with sw_s == stable_mode clears the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- States: RUN, WAIT_FRAME, HOLD, SETTLE. All outputs are registered, so a transition at edge t is visible at t+1.
- RUN: timing_rst=0, blank=0, busy=0. If stable_mode != mode_sel -> WAIT_FRAME.
- WAIT_FRAME: blank=0, timing_rst=0, busy=1.
  - If stable_mode == mode_sel (switch reverted after debounce) -> RUN; cancelled, no blank.
  - Otherwise, on frame_end -> HOLD, and in the same edge mode_sel <= stable_mode.
  - If revert and frame_end occur in the same cycle, the revert wins.
- HOLD: timing_rst=1, blank=1.
  - Stays exactly RST_CYCLES cycles (counter 0..RST_CYCLES-1), then -> SETTLE.
  - After reset, the first HOLD uses mode_sel=0.
- SETTLE: timing_rst=0, blank=1.
  - Counts frame_end pulses; on the SETTLE_FRAMES-th pulse -> RUN, so blank=0 on the following cycle.
- Switch changes during HOLD/SETTLE do not abort the sequence. stable_mode keeps tracking; on entry to RUN it is compared again and a new sequence starts the next cycle if it differs.
- frame_end in RUN or HOLD is ignored. Counters clear on every state entry.
- The outputs drive the mux/generators only; this block never touches the RGB data itself.

Optional Feature:
Macro VGA_MODE_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT_FRAME and SETTLE since state entry or since the last frame_end.
  - On reaching FRAME_TIMEOUT, the FSM acts as if frame_end had arrived that cycle, the watchdog clears, and timeout_seen <= 1.
  - timeout_seen stays 1 until reset_n.
- Undefined: no watchdog, WAIT_FRAME and SETTLE wait indefinitely, and timeout_seen is tied 0.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, RST_CYCLES=3, SETTLE_FRAMES=2, FRAME_TIMEOUT=50.
1. Reset release, then two frame_end pulses -> HOLD for 3 cycles (timing_rst=1, blank=1, mode_sel=0), then SETTLE; blank drops to 0 one cycle after the second pulse; busy=0.
2. In RUN, set choose_vga_mode=1 and hold -> WAIT_FRAME after 2 sync + 4 debounce cycles; frame_end at t gives mode_sel=1, timing_rst=1, blank=1 at t+1; timing_rst=0 at t+4; after 2 more pulses blank=0, mode_sel stays 1.
3. Switch glitch of 3 cycles (< DEBOUNCE_CYCLES) -> no state change, busy stays 0.
4. Switch debounced to 1, then debounced back to 0 before any frame_end -> WAIT_FRAME returns to RUN, blank never asserted, mode_sel=0.
5. Switch toggled during SETTLE -> sequence completes to RUN, then a second switch sequence starts on the next cycle back to the new target.
6. With VGA_MODE_SEQ_TIMEOUT_EN and no frame_end after a switch request -> HOLD entered 50 cycles after WAIT_FRAME entry, timeout_seen=1; SETTLE exits after 2x50 cycles; timeout_seen is cleared only by reset_n=0, asynchronously, mid-sequence, returning to HOLD with mode_sel=0.
